// File: rtl/multiword_adder_scheduler.sv
// multiword_adder_scheduler: two requesters share one W-bit PG ripple adder; each K*W-bit add runs LSW first, one word per cycle
// Ports: clk, rst (sync, active-high); i_req0/1, i_a0/1, i_b0/1, i_sub0/1 requester side;
//        o_ack0/1 capture pulse, o_busy, o_done pulse, o_done_id, o_sum, o_cout registered results.
// Define ADDSCHED_SUB_EN to honour i_sub0/1 (a-b via inverted B words and carry-in 1).
`timescale 1ns/1ps
module multiword_adder_scheduler #(
  parameter int W = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req0,
  input  logic         i_req1,
  input  logic [K*W-1:0] i_a0,
  input  logic [K*W-1:0] i_b0,
  input  logic [K*W-1:0] i_a1,
  input  logic [K*W-1:0] i_b1,
  input  logic         i_sub0,
  input  logic         i_sub1,
  output logic         o_ack0,
  output logic         o_ack1,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_done_id,
  output logic [K*W-1:0] o_sum,
  output logic         o_cout
);
  localparam int N = K * W;
  localparam int IW = $clog2(K);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [N-1:0] r_a, r_b, r_work, r_sum;
  logic [IW-1:0] r_idx;
  logic r_carry, r_prio, r_own, r_cout, r_done, r_done_id, r_ack0, r_ack1, r_busy;
  logic w_cap, w_gnt1, w_last, w_sub, w_cout;
  logic [W-1:0] w_b, w_p, w_g, w_s;
  logic [W:0] w_c;
`ifdef ADDSCHED_SUB_EN
  logic r_sub;
  assign w_sub = w_gnt1 ? i_sub1 : i_sub0;
  assign w_b = r_b[W-1:0] ^ {W{r_sub}};
  always_ff @(posedge clk)
    if (rst) r_sub <= 1'b0;
    else if (w_cap) r_sub <= w_sub;
`else
  logic w_unused;
  assign w_unused = i_sub0 ^ i_sub1;
  assign w_sub = 1'b0;
  assign w_b = r_b[W-1:0];
`endif
  // r_prio=1 means requester 1 is favoured when both ask
  always_comb begin
    w_cap = (r_state == IDLE) & (i_req0 | i_req1);
    w_gnt1 = i_req1 & (~i_req0 | r_prio);
    w_last = (r_state == RUN) & (r_idx == IW'(K - 1));
  end
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = w_cap ? RUN : w_last ? IDLE : r_state;
  // operands shift right each cycle so the active word always sits in the low W bits
  assign w_p = r_a[W-1:0] ^ w_b;
  assign w_g = r_a[W-1:0] & w_b;
  always_comb begin
    w_c = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < W; i++) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    w_s = w_p ^ w_c[W-1:0];
    w_cout = w_c[W];
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_work <= '0;
      r_sum <= '0;
      r_idx <= '0;
      r_carry <= 1'b0;
      r_prio <= 1'b0;
      r_own <= 1'b0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
      r_done_id <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack0 <= w_cap & ~w_gnt1;
      r_ack1 <= w_cap & w_gnt1;
      r_done <= w_last;
      if (w_cap) begin
        r_a <= w_gnt1 ? i_a1 : i_a0;
        r_b <= w_gnt1 ? i_b1 : i_b0;
        r_carry <= w_sub;
        r_idx <= '0;
        r_own <= w_gnt1;
        r_prio <= ~w_gnt1;
        r_busy <= 1'b1;
      end else if (r_state == RUN) begin
        r_a <= r_a >> W;
        r_b <= r_b >> W;
        r_work <= {w_s, r_work[N-1:W]};
        r_carry <= w_cout;
        r_idx <= r_idx + IW'(1);
        if (w_last) begin
          r_sum <= {w_s, r_work[N-1:W]};
          r_cout <= w_cout;
          r_done_id <= r_own;
          r_busy <= 1'b0;
        end
      end
    end
  assign o_ack0 = r_ack0;
  assign o_ack1 = r_ack1;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_done_id = r_done_id;
  assign o_sum = r_sum;
  assign o_cout = r_cout;
endmodule

// File: tb/tb_multiword_adder_scheduler.sv
// tb_multiword_adder_scheduler: directed checks of timing, carry chain, subtract, arbitration, lockout and reset
`timescale 1ns/1ps
module tb_multiword_adder_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req0 = 0, i_req1 = 0, i_sub0 = 0, i_sub1 = 0;
  logic [63:0] i_a0 = 0, i_b0 = 0, i_a1 = 0, i_b1 = 0;
  logic o_ack0, o_ack1, o_busy, o_done, o_done_id, o_cout;
  logic [63:0] o_sum;
  int n_chk = 0, n_fail = 0, cyc = 0;
  multiword_adder_scheduler #(.W(16), .K(4)) dut (
    .clk(clk), .rst(rst), .i_req0(i_req0), .i_req1(i_req1),
    .i_a0(i_a0), .i_b0(i_b0), .i_a1(i_a1), .i_b1(i_b1),
    .i_sub0(i_sub0), .i_sub1(i_sub1), .o_ack0(o_ack0), .o_ack1(o_ack1),
    .o_busy(o_busy), .o_done(o_done), .o_done_id(o_done_id),
    .o_sum(o_sum), .o_cout(o_cout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_op(input string tag, input logic who, input logic [63:0] a, b,
                       input logic s, input logic [63:0] es, input logic ec);
    if (who) begin i_req1 = 1; i_a1 = a; i_b1 = b; i_sub1 = s; end
    else begin i_req0 = 1; i_a0 = a; i_b0 = b; i_sub0 = s; end
    cyc = 0;
    tick;
    check({tag, ".ack"}, {o_ack1, o_ack0, o_busy}, {who, !who, 1'b1});
    i_req0 = 0;
    i_req1 = 0;
    repeat (3) begin
      tick;
      check({tag, ".run"}, {o_done, o_busy}, 2'b01);
    end
    tick;
    check({tag, ".done"}, {o_done, o_busy, o_done_id}, {2'b10, who});
    check({tag, ".sum"}, o_sum, es);
    check({tag, ".cout"}, o_cout, ec);
    tick;
    check({tag, ".hold"}, {o_done, o_sum}, {1'b0, es});
  endtask
  initial begin
    int a0c, a1c, d0c, d1c, dn;
    logic [63:0] s0, s1;
    repeat (2) tick;
    check("rst.out", {o_ack0, o_ack1, o_busy, o_done, o_done_id, o_cout}, 6'b0);
    check("rst.sum", o_sum, 64'h0);
    rst = 0;
    tick;
    do_op("xword", 0, 64'h0000_0000_0000_FFFF, 64'h1, 0, 64'h0000_0000_0001_0000, 0);
    do_op("chain", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 64'h0, 1);
`ifdef ADDSCHED_SUB_EN
    do_op("sub57", 1, 64'd5, 64'd7, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    do_op("sub75", 1, 64'd7, 64'd5, 1, 64'd2, 1);
`else
    do_op("sub57", 1, 64'd5, 64'd7, 1, 64'd12, 0);
    do_op("sub75", 1, 64'd7, 64'd5, 1, 64'd12, 0);
`endif
    // both requesting right after reset
    rst = 1;
    tick;
    rst = 0;
    i_a0 = 64'd1; i_b0 = 64'd2; i_sub0 = 0;
    i_a1 = 64'd10; i_b1 = 64'd20; i_sub1 = 0;
    i_req0 = 1;
    i_req1 = 1;
    a0c = 0; a1c = 0; d0c = 0; d1c = 0; s0 = 0; s1 = 0;
    cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (o_ack0) begin a0c = c; i_req0 = 0; end
      if (o_ack1) begin a1c = c; i_req1 = 0; end
      if (o_done && !o_done_id) begin d0c = c; s0 = o_sum; end
      if (o_done && o_done_id) begin d1c = c; s1 = o_sum; end
    end
    check("arb.ack0", a0c, 1);
    check("arb.done0", {d0c[7:0], s0}, {8'd5, 64'd3});
    check("arb.ack1", a1c, 6);
    check("arb.done1", {d1c[7:0], s1}, {8'd10, 64'd30});
    i_req0 = 1;
    i_req1 = 1;
    tick;
    check("arb.again", {o_ack0, o_ack1}, 2'b10);
    i_req0 = 0;
    i_req1 = 0;
    repeat (4) tick;
    check("arb.again.done", {o_done, o_done_id}, 2'b10);
    // req1 arrives while req0 runs
    i_a1 = 64'd100; i_b1 = 64'd23;
    i_req0 = 1;
    a1c = 0;
    d1c = 0;
    cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (o_ack0) i_req0 = 0;
      if (c == 2) i_req1 = 1;
      if (o_ack1 && a1c == 0) begin a1c = c; i_req1 = 0; end
      if (o_done && o_done_id) d1c = c;
    end
    check("lock.ack1", a1c, 6);
    check("lock.done1", {d1c[7:0], o_sum}, {8'd10, 64'd123});
    // reset in the middle of an operation
    i_a0 = 64'd9; i_b0 = 64'd9;
    i_req0 = 1;
    cyc = 0;
    tick;
    check("mid.ack", o_ack0, 1);
    i_req0 = 0;
    tick;
    tick;
    rst = 1;
    tick;
    rst = 0;
    check("mid.busy", {o_busy, o_done}, 2'b00);
    check("mid.res", {o_cout, o_sum}, 65'h0);
    dn = 0;
    repeat (6) begin
      tick;
      if (o_done) dn++;
    end
    check("mid.nodone", dn, 0);
    i_req0 = 1;
    i_req1 = 1;
    tick;
    check("mid.prio", {o_ack0, o_ack1}, 2'b10);
    i_req0 = 0;
    i_req1 = 0;
    repeat (4) tick;
    check("mid.after", {o_done, o_done_id, o_sum}, {2'b10, 64'd18});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multiword_adder_scheduler.md
# multiword_adder_scheduler

Shares one W-bit PG carry-ripple adder between two requesters and sequences each K·W-bit addition (or subtraction) through it one word per cycle, LSW first, with the inter-word carry held in a register. It sits between two operand producers and the single adder datapath. It provides round-robin arbitration, a req/ack handshake, and a registered result with a done pulse.

## Interface
- W, 16, adder width in bits (≥2)
- K, 4, words per operand (≥2); operand width is K·W
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0, req1  in  1  request from requester 0 / 1; held high until ack seen
- a0, b0, a1, b1  in  K·W  operands; stable while the matching req is high
- sub0, sub1  in  1  1 = compute a−b, 0 = a+b
- ack0, ack1  out  1  one-cycle pulse; the request was captured
- busy  out  1  high while words are being computed
- done  out  1  one-cycle pulse; sum/cout/done_id valid
- done_id  out  1  requester that owns the current result
- sum  out  K·W  result; holds between done pulses
- cout  out  1  final carry out (subtract: 1 = no borrow, a ≥ b)

## Operation
- Exactly one W-bit PG carry-ripple adder instance: bitwise P=a^b, G=a&b; ripple group PG; sum = P^C.
- States: IDLE and RUN.
- IDLE: if any req is high at a rising edge:
  - Arbitrate and capture the winner's a, b, sub into internal registers.
  - Set carry_reg = sub (0 when the macro is absent) and word index idx = 0.
  - Go to RUN.
  - No req: stay in IDLE.
- Arbitration, round robin:
  - Single requester wins unconditionally.
  - Both requesting: the requester not granted last wins.
  - Priority pointer resets to favour requester 0 and updates on every grant.
- RUN, each cycle:
  - Adder inputs: A = a_reg word idx, B = b_reg word idx XOR {W{sub_reg}}, Cin = carry_reg.
  - At the edge: store the word into the working register, carry_reg ← adder Cout, idx ← idx+1.
  - At idx = K−1: sum ← completed working value, cout ← final Cout, done_id ← owner, done pulses, go to IDLE.
- Requests arriving during RUN are not sampled. A req still high when IDLE is re-entered is a new request.
- Arithmetic is modulo 2^(K·W). No overflow flag.
- Reset (including mid-RUN):
  - Go to IDLE; the in-flight operation is discarded and no done is issued.
  - ack0 = ack1 = busy = done = done_id = cout = 0, sum = 0.
  - carry_reg = 0, idx = 0, priority → requester 0.

## Timing
- Cycle 0: req sampled high in IDLE.
- Cycle 1: ack of the winner = 1, busy = 1.
- Cycles 1..K: busy = 1, one word computed per cycle.
- Cycle K+1: done = 1, busy = 0, state IDLE; sum/cout/done_id valid from here and held until the next done.
- A req high in cycle K+1 is captured at that edge. Back-to-back throughput is one operation per K+1 cycles.
- sum, cout, done_id, ack, done, busy are all registered outputs. No combinational path from inputs to outputs.
- Adder critical path is W bits of ripple plus the B-inversion XOR per cycle.

## Configuration
- ADDSCHED_SUB_EN defined:
  - sub0/sub1 are honoured.
  - B words are inverted when sub=1; initial carry = sub.
- ADDSCHED_SUB_EN undefined:
  - sub0/sub1 are ignored; the sub register and inversion XORs are removed.
  - Initial carry is 0; every operation is an add.

## Test plan
W=16, K=4 for all scenarios.
- Cross-word carry: req0, a0=0x0000_0000_0000_FFFF, b0=1, sub0=0 → ack0 in cycle 1; done in cycle 5 with sum=0x0000_0000_0001_0000, cout=0, done_id=0.
- Full carry chain: a0=0xFFFF_FFFF_FFFF_FFFF, b0=1 → sum=0, cout=1.
- Subtract, macro on:
  - a1=5, b1=7, sub1=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0.
  - a1=7, b1=5 → sum=2, cout=1.
  - Same stimulus with the macro off → sum=12 and sum=12, cout=0.
- Arbitration: req0 and req1 both high from cycle 0 after reset → ack0 in cycle 1, done in cycle 5 (id 0); ack1 in cycle 6, done in cycle 10 (id 1). Both high again in cycle 10 → requester 0 wins.
- Busy lockout: req1 raised in cycle 2 while req0's operation runs → no ack1 before cycle 6; req1 captured at the cycle-5 edge.
- Reset mid-operation: rst high in cycle 3 → cycle 4 shows busy=0; no done follows; sum=0, cout=0; the next simultaneous request grants requester 0.
